// File: rtl/sequential_alu.sv
// Sequential ALU: single-cycle arithmetic/logic operations plus a
// shift-add multiplier that runs for WIDTH cycles. All outputs are registered.
module sequential_alu #(
    parameter int WIDTH = 4
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [2:0]           func,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b_ext,
    input  logic                 use_reg,
    input  logic                 cin,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy,
    output logic                 done
);

    localparam int RW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t              state_r;
    logic [RW-1:0]       result_r;
    logic                busy_r;
    logic                done_r;
    logic [RW-1:0]       prod_r;     // partial product, never shown on result
    logic [RW-1:0]       mcand_r;    // multiplicand, shifted left each MUL cycle
    logic [WIDTH-1:0]    mplier_r;   // multiplier, shifted right each MUL cycle
    logic [CNT_W-1:0]    cnt_r;

    logic [WIDTH-1:0]    b_sel_s;
    logic [WIDTH-1:0]    rc_sum_s;
    logic                rc_carry_s;
    logic [RW-1:0]       op_result_s;
    logic [RW-1:0]       prod_next_s;

    assign result = result_r;
    assign busy   = busy_r;
    assign done   = done_r;

    // B operand source: the previous registered result or the external input.
    always_comb begin
        if (use_reg) begin
            b_sel_s = result_r[WIDTH-1:0];
        end else begin
            b_sel_s = b_ext;
        end
    end

    // WIDTH-stage ripple-carry adder: one full adder per bit, carry chained LSB to MSB.
    always_comb begin
        logic c;
        c        = cin;
        rc_sum_s = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            rc_sum_s[i] = a[i] ^ b_sel_s[i] ^ c;
            c           = (a[i] & b_sel_s[i]) | (c & (a[i] ^ b_sel_s[i]));
        end
        rc_carry_s = c;
    end

    // Single-cycle operation results, selected by func.
    always_comb begin
        op_result_s = {RW{1'b0}};
        case (func)
            3'd0: op_result_s = RW'({1'b0, a} + (WIDTH + 1)'(1) + (WIDTH + 1)'(cin));
            3'd1: op_result_s = RW'({rc_carry_s, rc_sum_s});
            3'd2: op_result_s = RW'({1'b0, a} + {1'b0, b_sel_s});
            3'd3: op_result_s = {a | b_sel_s, a ^ b_sel_s};
            3'd4: op_result_s = {{(RW - 1){1'b0}}, |{a, b_sel_s}};
            3'd5: op_result_s = {a, b_sel_s};
            3'd7: op_result_s = {RW{1'b0}};
            default: op_result_s = {RW{1'b0}};
        endcase
    end

    // Shift-add step: accumulate the multiplicand when the current multiplier LSB is set.
    always_comb begin
        if (mplier_r[0]) begin
            prod_next_s = prod_r + mcand_r;
        end else begin
            prod_next_s = prod_r;
        end
    end

    // Control FSM with registered result/busy/done and multiplier datapath.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= IDLE;
            result_r <= {RW{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            prod_r   <= {RW{1'b0}};
            mcand_r  <= {RW{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        if (func == 3'd6) begin
                            state_r  <= MUL;
                            busy_r   <= 1'b1;
                            done_r   <= 1'b0;
                            prod_r   <= {RW{1'b0}};
                            mcand_r  <= RW'(a);
                            mplier_r <= b_sel_s;
                            cnt_r    <= {CNT_W{1'b0}};
                        end else begin
                            result_r <= op_result_s;
                            done_r   <= 1'b1;
                        end
                    end else begin
                        done_r <= 1'b0;
                    end
                end
                MUL: begin
                    // start is deliberately ignored here; nothing is queued
                    prod_r   <= prod_next_s;
                    mcand_r  <= {mcand_r[RW-2:0], 1'b0};
                    mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
                    cnt_r    <= cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_W'(WIDTH - 1)) begin
                        state_r  <= IDLE;
                        result_r <= prod_next_s;
                        busy_r   <= 1'b0;
                        done_r   <= 1'b1;
                    end else begin
                        done_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sequential_alu.sv
// Directed self-checking bench for sequential_alu with WIDTH=4.
module tb_sequential_alu;

    logic       clock;
    logic       reset_n;
    logic       start;
    logic [2:0] func;
    logic [3:0] a;
    logic [3:0] b_ext;
    logic       use_reg;
    logic       cin;
    logic [7:0] result;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    sequential_alu #(.WIDTH(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .func    (func),
        .a       (a),
        .b_ext   (b_ext),
        .use_reg (use_reg),
        .cin     (cin),
        .result  (result),
        .busy    (busy),
        .done    (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One start pulse; returns at the falling edge after the capturing edge.
    task automatic pulse(input logic [2:0] f, input logic [3:0] av, input logic [3:0] bv,
                         input logic ur, input logic ci);
        @(negedge clock);
        func = f; a = av; b_ext = bv; use_reg = ur; cin = ci; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        a = 4'h0; b_ext = 4'h0; cin = 1'b0;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; start = 1'b1; func = 3'd5; a = 4'hF; b_ext = 4'hF; use_reg = 1'b0; cin = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            total++;
            if (result !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
                bad++;
                $display("FAIL reset got result=%h busy=%b done=%b exp 00/0/0", result, busy, done);
            end
        end
        start = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        total++;
        if (result !== 8'h00 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_release got result=%h done=%b exp 00/0", result, done);
        end
    endtask

    task automatic test_ripple;
        pulse(3'd1, 4'hF, 4'h1, 1'b0, 1'b1);
        total++;
        if (result !== 8'h11 || done !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL ripple got result=%h done=%b busy=%b exp 11/1/0", result, done, busy);
        end
        @(negedge clock);
        total++;
        if (result !== 8'h11 || done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL ripple_hold got result=%h done=%b busy=%b exp 11/0/0", result, done, busy);
        end
        pulse(3'd1, 4'h5, 4'h3, 1'b0, 1'b0);
        total++;
        if (result !== 8'h08) begin
            bad++;
            $display("FAIL ripple_nocin got=%h exp=08", result);
        end
    endtask

    task automatic test_arith;
        pulse(3'd0, 4'hF, 4'h0, 1'b0, 1'b1);
        total++;
        if (result !== 8'h11) begin
            bad++;
            $display("FAIL inc_cin got=%h exp=11", result);
        end
        pulse(3'd0, 4'h6, 4'h0, 1'b0, 1'b0);
        total++;
        if (result !== 8'h07) begin
            bad++;
            $display("FAIL inc got=%h exp=07", result);
        end
        pulse(3'd2, 4'hF, 4'hF, 1'b0, 1'b1);
        total++;
        if (result !== 8'h1E) begin
            bad++;
            $display("FAIL add_nocin got=%h exp=1e", result);
        end
    endtask

    task automatic test_logic;
        pulse(3'd3, 4'hA, 4'h6, 1'b0, 1'b0);
        total++;
        if (result !== 8'hEC) begin
            bad++;
            $display("FAIL or_xor got=%h exp=ec", result);
        end
        pulse(3'd4, 4'h0, 4'h0, 1'b0, 1'b0);
        total++;
        if (result !== 8'h00) begin
            bad++;
            $display("FAIL redor_zero got=%h exp=00", result);
        end
        pulse(3'd4, 4'h0, 4'h8, 1'b0, 1'b0);
        total++;
        if (result !== 8'h01) begin
            bad++;
            $display("FAIL redor_one got=%h exp=01", result);
        end
        pulse(3'd7, 4'hF, 4'hF, 1'b0, 1'b1);
        total++;
        if (result !== 8'h00 || done !== 1'b1) begin
            bad++;
            $display("FAIL clear got result=%h done=%b exp 00/1", result, done);
        end
    endtask

    task automatic test_mul;
        int n;
        int g;
        pulse(3'd5, 4'hA, 4'h5, 1'b0, 1'b0);
        pulse(3'd6, 4'hF, 4'hD, 1'b0, 1'b0);
        n = 0;
        g = 0;
        while (done !== 1'b1 && g < 12) begin
            if (busy === 1'b1) n++;
            total++;
            if (result !== 8'hA5) begin
                bad++;
                $display("FAIL mul_hold got=%h exp=a5", result);
            end
            @(negedge clock);
            g++;
        end
        total++;
        if (done !== 1'b1 || result !== 8'hC3 || busy !== 1'b0 || n != 4) begin
            bad++;
            $display("FAIL mul got result=%h done=%b busy=%b busy_cycles=%0d exp c3/1/0/4",
                     result, done, busy, n);
        end
        @(negedge clock);
        total++;
        if (done !== 1'b0 || result !== 8'hC3) begin
            bad++;
            $display("FAIL mul_after got done=%b result=%h exp 0/c3", done, result);
        end
        // a clear request issued mid-multiply must be dropped
        pulse(3'd6, 4'hF, 4'hD, 1'b0, 1'b0);
        func = 3'd7; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        total++;
        if (done !== 1'b0 || busy !== 1'b1 || result !== 8'hC3) begin
            bad++;
            $display("FAIL mul_ignore got done=%b busy=%b result=%h exp 0/1/c3", done, busy, result);
        end
        g = 0;
        while (done !== 1'b1 && g < 12) begin
            @(negedge clock);
            g++;
        end
        total++;
        if (done !== 1'b1 || result !== 8'hC3) begin
            bad++;
            $display("FAIL mul2 got done=%b result=%h exp 1/c3", done, result);
        end
        @(negedge clock);
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== 8'hC3) begin
            bad++;
            $display("FAIL mul_noqueue got done=%b busy=%b result=%h exp 0/0/c3", done, busy, result);
        end
    endtask

    task automatic test_chain;
        pulse(3'd5, 4'h0, 4'h5, 1'b0, 1'b0);
        total++;
        if (result !== 8'h05) begin
            bad++;
            $display("FAIL chain_load got=%h exp=05", result);
        end
        pulse(3'd2, 4'h3, 4'hF, 1'b1, 1'b0);
        total++;
        if (result !== 8'h08) begin
            bad++;
            $display("FAIL chain_1 got=%h exp=08", result);
        end
        pulse(3'd2, 4'h3, 4'hF, 1'b1, 1'b0);
        total++;
        if (result !== 8'h0B) begin
            bad++;
            $display("FAIL chain_2 got=%h exp=0b", result);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clock);
        func = 3'd5; a = 4'h1; b_ext = 4'h2; use_reg = 1'b0; start = 1'b1;
        @(negedge clock);
        total++;
        if (result !== 8'h12 || done !== 1'b1) begin
            bad++;
            $display("FAIL b2b_first got result=%h done=%b exp 12/1", result, done);
        end
        func = 3'd2; a = 4'h1; use_reg = 1'b1;
        @(negedge clock);
        start = 1'b0; use_reg = 1'b0;
        total++;
        if (result !== 8'h03 || done !== 1'b1) begin
            bad++;
            $display("FAIL b2b_second got result=%h done=%b exp 03/1", result, done);
        end
        @(negedge clock);
        total++;
        if (done !== 1'b0 || result !== 8'h03) begin
            bad++;
            $display("FAIL b2b_end got done=%b result=%h exp 0/03", done, result);
        end
    endtask

    task automatic test_mid_reset;
        int g;
        int seen;
        pulse(3'd6, 4'h7, 4'h7, 1'b0, 1'b0);
        @(negedge clock);   // after MUL edge 1
        @(negedge clock);   // after MUL edge 2
        reset_n = 1'b0;
        #1;
        total++;
        if (result !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL midrst got result=%h busy=%b done=%b exp 00/0/0", result, busy, done);
        end
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (done === 1'b1) seen++;
        end
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (done === 1'b1) seen++;
        end
        total++;
        if (seen != 0 || busy !== 1'b0 || result !== 8'h00) begin
            bad++;
            $display("FAIL midrst_nodone got done_pulses=%0d busy=%b result=%h exp 0/0/00",
                     seen, busy, result);
        end
        pulse(3'd6, 4'h7, 4'h7, 1'b0, 1'b0);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL midrst_restart got busy=%b exp 1", busy);
        end
        g = 0;
        while (done !== 1'b1 && g < 12) begin
            @(negedge clock);
            g++;
        end
        total++;
        if (done !== 1'b1 || result !== 8'h31) begin
            bad++;
            $display("FAIL midrst_mul got done=%b result=%h exp 1/31", done, result);
        end
    endtask

    initial begin
        test_reset();
        test_ripple();
        test_arith();
        test_logic();
        test_mul();
        test_chain();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sequential_alu.md
SEQUENTIAL_ALU -- requirements
Module: sequential_alu

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits; legal range 2..16.
REQ-002 Ports: clock  in  1  rising-edge system clock.
REQ-003 Ports: reset_n  in  1  asynchronous, active-low reset.
REQ-004 Ports: start  in  1  operation request, sampled on rising edge of clock.
REQ-005 Ports: func  in  3  operation select, sampled with start.
REQ-006 Ports: a  in  WIDTH  operand A.
REQ-007 Ports: b_ext  in  WIDTH  external operand B.
REQ-008 Ports: use_reg  in  1  B source select: 1 = result[WIDTH-1:0], 0 = b_ext.
REQ-009 Ports: cin  in  1  carry-in for func 0 and 1.
REQ-010 Ports: result  out  2*WIDTH  registered result.
REQ-011 Ports: busy  out  1  high while a multi-cycle operation runs.
REQ-012 Ports: done  out  1  one-cycle pulse marking result update.

Function
REQ-013 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-014 FSM states SHALL be IDLE and MUL; reset state IDLE.
REQ-015 IDLE with start=1 SHALL capture func, a, and selected B (use_reg mux) on that edge; later input changes do not affect the operation.
REQ-016 func 0: result = zero-extended {carry, sum} of A + 1 + cin.
REQ-017 func 1: result = zero-extended {carry, sum} of A + B + cin, built as a WIDTH-stage ripple-carry adder.
REQ-018 func 2: result = zero-extended A + B (no cin).
REQ-019 func 3: result = {A | B, A ^ B}.
REQ-020 func 4: result = {(2*WIDTH-1) zeros, reduction-OR of {A, B}}.
REQ-021 func 5: result = {A, B}.
REQ-022 func 6: result = unsigned A * B, computed by shift-add over exactly WIDTH cycles in state MUL.
REQ-023 func 7: result cleared to 0.
REQ-024 Funcs 0-5 and 7: result and done=1 SHALL update on the edge sampling start; state stays IDLE; busy stays 0.
REQ-025 func 6: the start edge SHALL enter MUL, clear the partial product, and set busy=1; each MUL edge processes one multiplier bit, LSB first.
REQ-026 On the WIDTH-th MUL edge: result = full product, done=1, busy=0, state returns to IDLE.
REQ-027 result SHALL hold its value between updates; intermediate partial products SHALL never appear on result.
REQ-028 done SHALL be high for exactly one cycle per completed operation and low otherwise.
REQ-029 start while busy=1 SHALL be ignored and not queued.
REQ-030 start in the done cycle (IDLE) SHALL be accepted normally, giving back-to-back operations.
REQ-031 With use_reg=1, B SHALL be the result value present before the capturing edge.
REQ-032 Arithmetic SHALL be unsigned; sums wrap at 2*WIDTH bits, which cannot overflow given the operand widths.

Reset
REQ-033 reset_n=0 SHALL asynchronously force state=IDLE, result=0, busy=0, done=0, and clear captured operands and partial product.
REQ-034 Reset asserted during MUL SHALL abort the operation with no done pulse; after release the block is IDLE and accepts start on the next edge.
REQ-035 start coincident with the reset_n release edge SHALL be ignored.

Verification (WIDTH=4)
REQ-036 Reset: reset_n=0 from power-up -> result=8'h00, busy=0, done=0 regardless of clock and inputs.
REQ-037 Ripple add: func=1, a=4'hF, b_ext=4'h1, cin=1, use_reg=0, one start pulse -> result=8'h11 and done=1 for exactly one cycle after the edge; busy stays 0.
REQ-038 Logic: func=3, a=4'hA, b_ext=4'h6 -> result=8'hEC. Then func=4, a=0, b_ext=0 -> result=8'h00. Then func=4, a=0, b_ext=4'h8 -> result=8'h01.
REQ-039 Multiply: func=6, a=4'hF, b_ext=4'hD -> busy=1 for 4 cycles, result held at prior value during busy, then result=8'hC3 with done=1. A start with func=7 issued during busy -> ignored, result stays 8'hC3.
REQ-040 Register chaining: func=5, a=0, b_ext=5 -> result=8'h05. Then func=2, a=3, use_reg=1 -> result=8'h08. Then func=2, a=3, use_reg=1 -> result=8'h0B.
REQ-041 Mid-operation reset: func=6, a=4'h7, b_ext=4'h7; reset_n=0 asserted between MUL edges 2 and 3 -> result=0 and busy=0 immediately, no done pulse. After release, func=6 with the same operands -> result=8'h31.
